// File: rtl/ucsbece154b_perf_pkg.sv
// Shared definitions for the dual-issue performance monitor: opcodes, counter
// indices (which double as rd_sel codes), FSM states and small decode helpers.
package ucsbece154b_perf_pkg;

   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   // Counter slots; the index of each counter is also its rd_sel code.
   localparam int CNT_CYCLES   = 0;
   localparam int CNT_INSTRS   = 1;
   localparam int CNT_BRANCHES = 2;
   localparam int CNT_BR_MISS  = 3;
   localparam int CNT_JUMPS    = 4;
   localparam int CNT_JMP_MISS = 5;
   localparam int CNT_DUAL     = 6;
   localparam int NUM_CNT      = 7;

   localparam logic [2:0] SEL_STATUS = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2
   } perf_state_e;

   function automatic logic is_jump(input logic [6:0] op);
      return (op == OP_JAL) || (op == OP_JALR);
   endfunction

   function automatic logic [1:0] count2(input logic a, input logic b);
      return {1'b0, a} + {1'b0, b};
   endfunction

endpackage

// File: rtl/ucsbece154b_sat_counter.sv
// Saturating event counter: adds 0..2 per cycle and sticks at all-ones.
module ucsbece154b_sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic [1:0]   inc,
   output logic [W-1:0] cnt
);

   logic [W:0] sum;

   // One extra bit catches the wrap so a +2 from all-ones-1 still lands on all-ones.
   assign sum = {1'b0, cnt} + {{(W-1){1'b0}}, inc};

   // NOTE: sequential state is written with <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset || clr) begin
         cnt <= '0;
      end else if (sum[W]) begin
         cnt <= '1;
      end else begin
         cnt <= sum[W-1:0];
      end
   end

endmodule

// File: rtl/ucsbece154b_perf_monitor.sv
// Performance monitor for the dual-issue pipeline: run/halt FSM, fetch-slot
// halt detector, execute-slot event decode and a registered counter read port.
module ucsbece154b_perf_monitor
   import ucsbece154b_perf_pkg::*;
#(
   parameter int          CNT_W    = 32,
   parameter logic [31:0] HALT_NOP = 32'h00000013,
   parameter int          HALT_CYC = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable_i,
   input  logic             clear_i,
   input  logic [31:0]      pc1_e_i,
   input  logic [6:0]       op1_e_i,
   input  logic             misp1_e_i,
   input  logic             predtk1_e_i,
   input  logic [31:0]      pc2_e_i,
   input  logic [6:0]       op2_e_i,
   input  logic             misp2_e_i,
   input  logic             predtk2_e_i,
   input  logic [31:0]      pcf1_i,
   input  logic [31:0]      instrf1_i,
   input  logic [31:0]      pcf2_i,
   input  logic [31:0]      instrf2_i,
   input  logic             rd_req_i,
   input  logic [2:0]       rd_sel_i,
   output logic             rd_ack_o,
   output logic [CNT_W-1:0] rd_data_o,
   output logic             halted_o
);

   localparam int MW = (HALT_CYC > 1) ? $clog2(HALT_CYC) : 1;

   perf_state_e      state, state_nxt;
   logic [31:0]      prev_pcf1, prev_pcf2;
   logic [MW-1:0]    match_cnt;
   logic             run, fetch_match, halt_det;
   logic             v1, v2, br1, br2, jp1, jp2;
   logic [1:0]       inc [NUM_CNT];
   logic [CNT_W-1:0] cnt [NUM_CNT];
   logic [CNT_W-1:0] rd_mux;

   assign run = (state == ST_RUN);

   // Program end: both fetch slots spinning on the same PC with the terminal NOP.
   assign fetch_match = (pcf1_i == prev_pcf1) && (instrf1_i == HALT_NOP) &&
                        (pcf2_i == prev_pcf2) && (instrf2_i == HALT_NOP);
   assign halt_det    = fetch_match && (match_cnt == MW'(HALT_CYC - 1));

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_nxt = state;
      if (clear_i) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:   if (enable_i) state_nxt = ST_RUN;
            ST_RUN:    if (halt_det) state_nxt = ST_HALTED;
            ST_HALTED: state_nxt = ST_HALTED;
            default:   state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset || clear_i) begin
         prev_pcf1 <= '0;
         prev_pcf2 <= '0;
         match_cnt <= '0;
      end else if (run) begin
         prev_pcf1 <= pcf1_i;
         prev_pcf2 <= pcf2_i;
         if (!fetch_match) begin
            match_cnt <= '0;
         end else if (match_cnt != MW'(HALT_CYC - 1)) begin
            match_cnt <= match_cnt + 1'b1;
         end
      end
   end

   // halted_o trails the HALTED state by one cycle and drops with a clear.
   always_ff @(posedge clk) begin
      if (!reset) begin
         halted_o <= 1'b0;
      end else begin
         halted_o <= (state == ST_HALTED) && !clear_i;
      end
   end

   assign v1  = |pc1_e_i;
   assign v2  = |pc2_e_i;
   assign br1 = v1 && (op1_e_i == OP_BRANCH);
   assign br2 = v2 && (op2_e_i == OP_BRANCH);
   assign jp1 = v1 && is_jump(op1_e_i);
   assign jp2 = v2 && is_jump(op2_e_i);

   always_comb begin
      for (int i = 0; i < NUM_CNT; i++) inc[i] = 2'd0;
      if (run) begin
         inc[CNT_CYCLES]   = 2'd1;
         inc[CNT_INSTRS]   = count2(v1, v2);
         inc[CNT_BRANCHES] = count2(br1, br2);
         inc[CNT_BR_MISS]  = count2(br1 && misp1_e_i, br2 && misp2_e_i);
         inc[CNT_JUMPS]    = count2(jp1, jp2);
         inc[CNT_JMP_MISS] = count2(jp1 && !predtk1_e_i, jp2 && !predtk2_e_i);
         inc[CNT_DUAL]     = {1'b0, v1 && v2};
      end
   end

   for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
      ucsbece154b_sat_counter #(.W(CNT_W)) u_cnt (
         .clk   (clk),
         .reset (reset),
         .clr   (clear_i),
         .inc   (inc[g]),
         .cnt   (cnt[g])
      );
   end

   always_comb begin
      rd_mux = '0;
      if (rd_sel_i == SEL_STATUS) begin
         rd_mux = CNT_W'({halted_o, state});
      end else begin
         rd_mux = cnt[rd_sel_i];
      end
   end

   // Capture happens on the request edge, so a coincident increment is not visible.
   always_ff @(posedge clk) begin
      if (!reset) begin
         rd_ack_o  <= 1'b0;
         rd_data_o <= '0;
      end else begin
         rd_ack_o <= rd_req_i;
         if (rd_req_i) rd_data_o <= rd_mux;
      end
   end

endmodule
